// File: rtl/module_display_scan_multiplexer_pkg.sv
// Shared definitions for the display scan multiplexer and its prescaler.
//   clog2 / sel_w : width helpers usable in parameter and port declarations.
//   DEF_*         : default build constants for the chronometer display.
package module_display_scan_multiplexer_pkg;

  localparam int DEF_N_CHANNELS   = 4;
  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_PRESCALE     = 50000;
  localparam int DEF_BLANK_CYCLES = 1;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  // Width of an index or counter that must hold at least one bit.
  function automatic int sel_w(input int count);
    return (clog2(count) < 1) ? 1 : clog2(count);
  endfunction

endpackage

// File: rtl/module_display_scan_multiplexer_if.sv
// Bundle between the time/BCD logic (master) and the scan multiplexer (slave).
//   enable, channel_mask, channel_data : master -> slave scan controls and data
//   mux_output, channel_select,
//   channel_strobe, frame_start        : slave -> master display drive
interface module_display_scan_multiplexer_if
  import module_display_scan_multiplexer_pkg::*;
#(
  parameter int N_CHANNELS = DEF_N_CHANNELS,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

  localparam int SEL_W = sel_w(N_CHANNELS);

  logic                           enable;
  logic [N_CHANNELS-1:0]          channel_mask;
  logic [N_CHANNELS*DATA_WIDTH-1:0] channel_data;
  logic [DATA_WIDTH-1:0]          mux_output;
  logic [SEL_W-1:0]               channel_select;
  logic [N_CHANNELS-1:0]          channel_strobe;
  logic                           frame_start;

  modport master (
    output enable, channel_mask, channel_data,
    input  mux_output, channel_select, channel_strobe, frame_start
  );

  modport slave (
    input  enable, channel_mask, channel_data,
    output mux_output, channel_select, channel_strobe, frame_start
  );

endinterface

// File: rtl/module_display_scan_multiplexer_prescaler_tick.sv
// Free-running slot prescaler, reusable as a generic time-base divider.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   enable  : count advances only while high; holds otherwise
//   count   : current position 0..PRESCALE-1
//   tick    : high while enabled at the terminal count (wraps on this edge)
module module_prescaler_tick
  import module_display_scan_multiplexer_pkg::*;
#(
  parameter  int PRESCALE = DEF_PRESCALE,
  localparam int CNT_W    = sel_w(PRESCALE)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    tick    = enable && (count_q == LAST);
    count_d = count_q;
    if (enable) begin
      count_d = tick ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/module_display_scan_multiplexer.sv
// Time-division multiplexer for the multiplexed 7-segment display.
// Scans round-robin over the channels enabled in channel_mask, one slot of
// PRESCALE cycles each, and drives registered data/index/one-hot strobe.
// The strobe is held off for BLANK_CYCLES at the start of every slot so the
// previous digit's segments do not ghost onto the newly enabled digit.
//   clock, reset_n : rising-edge clock, asynchronous active-low reset
//   bus (slave)    : scan controls/data in, display drive out
module module_display_scan_multiplexer
  import module_display_scan_multiplexer_pkg::*;
#(
  parameter  int N_CHANNELS   = DEF_N_CHANNELS,
  parameter  int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter  int PRESCALE     = DEF_PRESCALE,
  parameter  int BLANK_CYCLES = DEF_BLANK_CYCLES,
  localparam int SEL_W        = sel_w(N_CHANNELS),
  localparam int CNT_W        = sel_w(PRESCALE)
) (
  input  logic                             clock,
  input  logic                             reset_n,
  module_display_scan_multiplexer_if.slave bus
);

  logic [CNT_W-1:0]      slot_count;
  logic                  slot_tick;

  logic [SEL_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] mux_q, mux_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [N_CHANNELS-1:0] strobe_q, strobe_d;
  logic                  frame_q, frame_d;

  logic [SEL_W-1:0]      next_idx;
  logic [N_CHANNELS-1:0] onehot;
  logic                  blank_done;
  logic [DATA_WIDTH-1:0] chan [N_CHANNELS];

  module_prescaler_tick #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (bus.enable),
    .count   (slot_count),
    .tick    (slot_tick)
  );

  // Next enabled channel after idx_q. Walking the offsets from N down to 1
  // lets the nearest candidate win; offset N is idx_q itself, so a mask with
  // only the current bit set keeps the index, and an empty mask holds it.
  always_comb begin
    int               cand;
    logic [SEL_W-1:0] cand_sel;
    next_idx = idx_q;
    cand     = 0;
    cand_sel = '0;
    for (int k = N_CHANNELS; k >= 1; k--) begin
      cand = int'(idx_q) + k;
      if (cand >= N_CHANNELS) begin
        cand = cand - N_CHANNELS;
      end
      cand_sel = SEL_W'(cand);
      if (bus.channel_mask[cand_sel]) begin
        next_idx = cand_sel;
      end
    end
  end

  always_comb begin
    onehot         = '0;
    onehot[idx_q]  = 1'b1;
    for (int i = 0; i < N_CHANNELS; i++) begin
      chan[i] = bus.channel_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    blank_done = (int'(slot_count) >= BLANK_CYCLES);
    idx_d      = slot_tick ? next_idx : idx_q;
    mux_d      = chan[idx_q];
    sel_d      = idx_q;
    strobe_d   = '0;
    if (bus.enable && bus.channel_mask[idx_q] && blank_done) begin
      strobe_d = onehot;
    end
    // A real advance needs at least one enabled channel; landing on an index
    // not above the old one means the scan wrapped (single channel included).
    frame_d    = slot_tick && (|bus.channel_mask) && (next_idx <= idx_q);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idx_q    <= '0;
      mux_q    <= '0;
      sel_q    <= '0;
      strobe_q <= '0;
      frame_q  <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      mux_q    <= mux_d;
      sel_q    <= sel_d;
      strobe_q <= strobe_d;
      frame_q  <= frame_d;
    end
  end

  assign bus.mux_output     = mux_q;
  assign bus.channel_select = sel_q;
  assign bus.channel_strobe = strobe_q;
  assign bus.frame_start    = frame_q;

endmodule

// File: tb/tb_module_display_scan_multiplexer.sv
module tb_module_display_scan_multiplexer;

  typedef struct {
    logic [7:0] mux;
    logic [1:0] sel;
    logic [3:0] stb;
    logic       frame;
  } exp_t;

  logic        clock;
  logic        reset_n;
  logic        en;
  logic [3:0]  mask_a;
  logic [31:0] data_a;
  logic [2:0]  mask_b;
  logic [23:0] data_b;

  int vectors;
  int miscompares;
  int cyc;

  // Reference model state: slot counter and channel index per DUT.
  int cnt_a, idx_a, cnt_b, idx_b;
  exp_t q_a[$];
  exp_t q_b[$];

  module_display_scan_multiplexer_if #(.N_CHANNELS(4), .DATA_WIDTH(8)) if_a ();
  module_display_scan_multiplexer_if #(.N_CHANNELS(3), .DATA_WIDTH(8)) if_b ();

  assign if_a.enable       = en;
  assign if_a.channel_mask = mask_a;
  assign if_a.channel_data = data_a;
  assign if_b.enable       = en;
  assign if_b.channel_mask = mask_b;
  assign if_b.channel_data = data_b;

  module_display_scan_multiplexer #(
    .N_CHANNELS(4), .DATA_WIDTH(8), .PRESCALE(4), .BLANK_CYCLES(1)
  ) dut_a (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (if_a)
  );

  module_display_scan_multiplexer #(
    .N_CHANNELS(3), .DATA_WIDTH(8), .PRESCALE(2), .BLANK_CYCLES(0)
  ) dut_b (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (if_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected register contents after the next rising edge, then model update.
  function automatic void model_step(input int n, input int p, input int blank,
                                     input logic e, input logic [3:0] mask,
                                     input logic [31:0] data,
                                     inout int cnt, inout int idx,
                                     output exp_t x);
    int  nxt;
    bit  found;
    x.mux   = data[idx*8 +: 8];
    x.sel   = 2'(idx);
    x.stb   = (e && mask[idx] && (cnt >= blank)) ? 4'(1 << idx) : 4'b0000;
    x.frame = 1'b0;
    if (e) begin
      if (cnt == p - 1) begin
        cnt   = 0;
        found = 0;
        nxt   = idx;
        for (int k = 1; k <= n; k++) begin
          int c;
          c = (idx + k) % n;
          if (!found && mask[c]) begin
            nxt   = c;
            found = 1;
          end
        end
        if (found) begin
          x.frame = (nxt <= idx);
          idx     = nxt;
        end
      end else begin
        cnt = cnt + 1;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_a_mux"},   if_a.mux_output, 8'h00);
    chk({tag, "_a_sel"},   {6'b0, if_a.channel_select}, 8'h00);
    chk({tag, "_a_stb"},   {4'b0, if_a.channel_strobe}, 8'h00);
    chk({tag, "_a_frame"}, {7'b0, if_a.frame_start}, 8'h00);
    chk({tag, "_b_mux"},   if_b.mux_output, 8'h00);
    chk({tag, "_b_sel"},   {6'b0, if_b.channel_select}, 8'h00);
    chk({tag, "_b_stb"},   {5'b0, if_b.channel_strobe}, 8'h00);
    chk({tag, "_b_frame"}, {7'b0, if_b.frame_start}, 8'h00);
  endtask

  task automatic step();
    exp_t ea, eb;
    model_step(4, 4, 1, en, mask_a, data_a, cnt_a, idx_a, ea);
    q_a.push_back(ea);
    model_step(3, 2, 0, en, {1'b0, mask_b}, {8'h00, data_b}, cnt_b, idx_b, eb);
    q_b.push_back(eb);
    @(posedge clock);
    #1;
    cyc++;
    ea = q_a.pop_front();
    eb = q_b.pop_front();
    chk("a_mux",   if_a.mux_output, ea.mux);
    chk("a_sel",   {6'b0, if_a.channel_select}, {6'b0, ea.sel});
    chk("a_stb",   {4'b0, if_a.channel_strobe}, {4'b0, ea.stb});
    chk("a_frame", {7'b0, if_a.frame_start}, {7'b0, ea.frame});
    chk("b_mux",   if_b.mux_output, eb.mux);
    chk("b_sel",   {6'b0, if_b.channel_select}, {6'b0, eb.sel});
    chk("b_stb",   {5'b0, if_b.channel_strobe}, {4'b0, eb.stb});
    chk("b_frame", {7'b0, if_b.frame_start}, {7'b0, eb.frame});
  endtask

  task automatic model_reset();
    cnt_a = 0; idx_a = 0; cnt_b = 0; idx_b = 0;
    q_a.delete();
    q_b.delete();
  endtask

  initial begin
    logic reached;
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    reset_n     = 1'b0;
    en          = 1'b1;
    mask_a      = 4'b1111;
    data_a      = 32'h44332211;
    mask_b      = 3'b111;
    data_b      = 24'h332211;
    model_reset();

    #1;
    chk_reset("rst0");
    repeat (2) @(posedge clock);
    #1;
    chk_reset("rst1");
    reset_n = 1'b1;

    // full scan, all channels
    for (int i = 0; i < 20; i++) step();

    // alternate channels
    mask_a = 4'b0101;
    data_a = 32'h44332255;
    for (int i = 0; i < 20; i++) step();

    // clear channel 1 in the middle of its slot
    mask_a  = 4'b1111;
    reached = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (idx_a == 1 && cnt_a == 2) begin
        reached = 1'b1;
        break;
      end
      step();
    end
    chk("sync_ch1", {7'b0, reached}, 8'h01);
    mask_a = 4'b1101;
    for (int i = 0; i < 20; i++) step();

    // freeze the scan mid-slot on channel 2
    mask_a  = 4'b1111;
    reached = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (idx_a == 2 && cnt_a == 2) begin
        reached = 1'b1;
        break;
      end
      step();
    end
    chk("sync_ch2", {7'b0, reached}, 8'h01);
    en = 1'b0;
    for (int i = 0; i < 10; i++) step();
    data_a = 32'h44AA2211;
    step();
    en = 1'b1;
    for (int i = 0; i < 10; i++) step();

    // empty mask, then a single channel
    mask_a = 4'b0000;
    for (int i = 0; i < 16; i++) step();
    mask_a = 4'b1000;
    for (int i = 0; i < 16; i++) step();

    // asynchronous reset pulse in the middle of a slot
    mask_a = 4'b1111;
    for (int i = 0; i < 6; i++) step();
    reset_n = 1'b0;
    #1;
    chk_reset("rst_mid");
    #1;
    reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < 12; i++) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
